// File: rtl/frogger_collision_scheduler_pkg.sv
// Shared definitions for the frog/car collision scheduler and its hit comparator.
//   - Default geometry (car slots, index width, coordinate width, row width).
//   - Scan FSM state encoding.
//   - Helper that sizes the wrap-aware X distance so no coordinate bit is lost.
package frogger_collision_scheduler_pkg;

  localparam int unsigned DEF_NUM_CARS   = 8;
  localparam int unsigned DEF_IDX_W      = 3;
  localparam int unsigned DEF_COORD_W    = 6;
  localparam int unsigned DEF_GAME_WIDTH = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Wide enough for both a full coordinate and the row width, plus one guard bit.
  function automatic int unsigned dx_width(input int unsigned coord_w,
                                           input int unsigned game_width);
    int unsigned gw_bits;
    gw_bits = $clog2(game_width + 1);
    return ((coord_w > gw_bits) ? coord_w : gw_bits) + 1;
  endfunction

endpackage

// File: rtl/frogger_hit_compare.sv
// Combinational frog/car hit test with horizontal wrap-around.
// A hit is a valid car in the frog's row whose X is the same tile or one tile
// to either side, where the row wraps modulo GAME_WIDTH.
// Ports:
//   frog_x, frog_y  in  COORD_W  frog tile position
//   car_x,  car_y   in  COORD_W  car tile position
//   car_valid       in  1        car slot is active
//   hit             out 1        car overlaps or touches the frog
module frogger_hit_compare
  import frogger_collision_scheduler_pkg::*;
#(
  parameter int unsigned COORD_W    = DEF_COORD_W,
  parameter int unsigned GAME_WIDTH = DEF_GAME_WIDTH
) (
  input  logic [COORD_W-1:0] frog_x,
  input  logic [COORD_W-1:0] frog_y,
  input  logic [COORD_W-1:0] car_x,
  input  logic [COORD_W-1:0] car_y,
  input  logic               car_valid,
  output logic               hit
);

  localparam int unsigned DX_W = dx_width(COORD_W, GAME_WIDTH);

  logic [DX_W-1:0] dx;

  // (car_x - frog_x) mod GAME_WIDTH via compare-and-subtract, no divider.
  always_comb begin
    dx = '0;
    if (car_x >= frog_x) begin
      dx = DX_W'(car_x) - DX_W'(frog_x);
    end else begin
      dx = DX_W'(GAME_WIDTH) - (DX_W'(frog_x) - DX_W'(car_x));
    end
  end

  always_comb begin
    hit = car_valid && (car_y == frog_y) &&
          ((dx == DX_W'(0)) || (dx == DX_W'(1)) || (dx == DX_W'(GAME_WIDTH - 1)));
  end

endmodule

// File: rtl/frogger_collision_scheduler.sv
// Per-frame collision scheduler: one shared hit comparator walks every car slot.
// A frame scan latches the frog position, steps the car table read address one
// slot per cycle, evaluates each car the cycle its data returns, and publishes
// a registered verdict (collided flag + lowest colliding index) with a Done pulse.
// Ports:
//   i_Clk, i_Rst       clock, synchronous active-high reset
//   i_Scan_Start       1-cycle scan request (accepted in IDLE or DONE only)
//   i_Frogger_X/Y      frog position, sampled when a scan is accepted
//   o_Car_Idx          car table read address (table answers one cycle later)
//   i_Car_X/Y, i_Car_Valid  car table read data for the previous address
//   o_Busy             scan in progress
//   o_Done             1-cycle pulse when the verdict outputs update
//   o_Collided         frame verdict, held between scans
//   o_Hit_Idx          lowest colliding car index, 0 when none
module frogger_collision_scheduler
  import frogger_collision_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CARS   = DEF_NUM_CARS,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned COORD_W    = DEF_COORD_W,
  parameter int unsigned GAME_WIDTH = DEF_GAME_WIDTH
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Scan_Start,
  input  logic [COORD_W-1:0] i_Frogger_X,
  input  logic [COORD_W-1:0] i_Frogger_Y,
  output logic [IDX_W-1:0]   o_Car_Idx,
  input  logic [COORD_W-1:0] i_Car_X,
  input  logic [COORD_W-1:0] i_Car_Y,
  input  logic               i_Car_Valid,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Collided,
  output logic [IDX_W-1:0]   o_Hit_Idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

  scan_state_t        state;
  logic [COORD_W-1:0] frog_x;
  logic [COORD_W-1:0] frog_y;

  // Evaluate stage: tracks which index the returning car data belongs to.
  logic               eval_pending;
  logic [IDX_W-1:0]   eval_idx;

  // First-hit accumulator for the current frame.
  logic               acc_hit;
  logic [IDX_W-1:0]   acc_idx;

  logic               car_hit;
  logic               eval_hit;

  frogger_hit_compare #(
    .COORD_W    (COORD_W),
    .GAME_WIDTH (GAME_WIDTH)
  ) u_hit_compare (
    .frog_x    (frog_x),
    .frog_y    (frog_y),
    .car_x     (i_Car_X),
    .car_y     (i_Car_Y),
    .car_valid (i_Car_Valid),
    .hit       (car_hit)
  );

  assign eval_hit = eval_pending & car_hit;

  // Scan FSM, read address counter, evaluate stage and verdict registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= ST_IDLE;
      frog_x       <= '0;
      frog_y       <= '0;
      eval_pending <= 1'b0;
      eval_idx     <= '0;
      acc_hit      <= 1'b0;
      acc_idx      <= '0;
      o_Car_Idx    <= '0;
      o_Busy       <= 1'b0;
      o_Done       <= 1'b0;
      o_Collided   <= 1'b0;
      o_Hit_Idx    <= '0;
    end else begin
      o_Done       <= 1'b0;
      // Data returned next cycle belongs to the address presented this cycle.
      eval_pending <= (state == ST_SCAN);
      eval_idx     <= o_Car_Idx;

      // Scan order is ascending, so the first hit is also the lowest index.
      if (eval_hit && !acc_hit) begin
        acc_hit <= 1'b1;
        acc_idx <= eval_idx;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_Scan_Start) begin
            state     <= ST_SCAN;
            frog_x    <= i_Frogger_X;
            frog_y    <= i_Frogger_Y;
            o_Car_Idx <= '0;
            acc_hit   <= 1'b0;
            acc_idx   <= '0;
            o_Busy    <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            o_Busy <= 1'b0;
          end
        end

        ST_SCAN: begin
          if (o_Car_Idx == LAST_IDX) begin
            state <= ST_DRAIN;
          end else begin
            o_Car_Idx <= o_Car_Idx + IDX_W'(1);
          end
        end

        ST_DRAIN: begin
          // Last car is evaluated now; fold its result straight into the verdict.
          state      <= ST_DONE;
          o_Busy     <= 1'b0;
          o_Done     <= 1'b1;
          o_Collided <= acc_hit | eval_hit;
          if (acc_hit) begin
            o_Hit_Idx <= acc_idx;
          end else if (eval_hit) begin
            o_Hit_Idx <= eval_idx;
          end else begin
            o_Hit_Idx <= '0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frogger_collision_scheduler.sv
// Self-checking bench for frogger_collision_scheduler: directed vector table,
// hand-written multi-cycle sequences and randomized frames against a reference.
module tb_frogger_collision_scheduler;

  localparam int unsigned NC = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 6;
  localparam int GW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] frog_x_in;
  logic [CW-1:0] frog_y_in;
  logic [IW-1:0] car_idx;
  logic [CW-1:0] car_x;
  logic [CW-1:0] car_y;
  logic          car_v;
  logic          busy;
  logic          done;
  logic          collided;
  logic [IW-1:0] hit_idx;

  always #5 clk = ~clk;

  frogger_collision_scheduler #(
    .NUM_CARS   (NC),
    .IDX_W      (IW),
    .COORD_W    (CW),
    .GAME_WIDTH (GW)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Scan_Start (start),
    .i_Frogger_X  (frog_x_in),
    .i_Frogger_Y  (frog_y_in),
    .o_Car_Idx    (car_idx),
    .i_Car_X      (car_x),
    .i_Car_Y      (car_y),
    .i_Car_Valid  (car_v),
    .o_Busy       (busy),
    .o_Done       (done),
    .o_Collided   (collided),
    .o_Hit_Idx    (hit_idx)
  );

  // Car position table: one-cycle registered read.
  int mem_x [NC];
  int mem_y [NC];
  bit mem_v [NC];

  always @(posedge clk) begin
    car_x <= CW'(mem_x[car_idx]);
    car_y <= CW'(mem_y[car_idx]);
    car_v <= mem_v[car_idx];
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_cars();
    for (int k = 0; k < NC; k++) begin
      mem_x[k] = 0;
      mem_y[k] = 0;
      mem_v[k] = 1'b0;
    end
  endtask

  // Reference: first car in index order whose modular X distance is 0 or +-1.
  task automatic ref_verdict(input int fx, input int fy, output bit col, output int idx);
    int d;
    col = 1'b0;
    idx = 0;
    for (int k = 0; k < NC; k++) begin
      d = (((mem_x[k] - fx) % GW) + GW) % GW;
      if (!col && mem_v[k] && mem_y[k] == fy && (d == 0 || d == 1 || d == GW - 1)) begin
        col = 1'b1;
        idx = k;
      end
    end
  endtask

  // Called at a negedge: raise start now, drop it next negedge and scramble the
  // frog inputs, then wait (bounded) for Done. lat = cycles after the accept edge.
  task automatic launch_now(input int fx, input int fy, output int lat);
    start     = 1'b1;
    frog_x_in = CW'(fx);
    frog_y_in = CW'(fy);
    @(negedge clk);
    start     = 1'b0;
    frog_x_in = CW'($urandom_range(GW - 1, 0));
    frog_y_in = CW'($urandom_range(7, 0));
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_scan(input int fx, input int fy, output int lat);
    @(negedge clk);
    launch_now(fx, fy, lat);
  endtask

  typedef struct {
    int fx;
    int fy;
    int cx [NC];
    int cy [NC];
    bit cv [NC];
    bit exp_col;
    int exp_idx;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic new_vec(input int v, input int fx, input int fy, input bit ec, input int ei);
    vecs[v].fx = fx;
    vecs[v].fy = fy;
    vecs[v].exp_col = ec;
    vecs[v].exp_idx = ei;
    for (int k = 0; k < NC; k++) begin
      vecs[v].cx[k] = 0;
      vecs[v].cy[k] = 0;
      vecs[v].cv[k] = 1'b0;
    end
  endtask

  task automatic set_car(input int v, input int k, input int x, input int y, input bit valid);
    vecs[v].cx[k] = x;
    vecs[v].cy[k] = y;
    vecs[v].cv[k] = valid;
  endtask

  task automatic load_vec(input int v);
    for (int k = 0; k < NC; k++) begin
      mem_x[k] = vecs[v].cx[k];
      mem_y[k] = vecs[v].cy[k];
      mem_v[k] = vecs[v].cv[k];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  d0;
    bit  rcol;
    int  ridx;
    int  rfx;
    int  rfy;

    // Directed vectors.
    new_vec(0, 5, 3, 1'b0, 0);
    new_vec(1, 5, 3, 1'b1, 2);  set_car(1, 2, 6, 3, 1'b1); set_car(1, 6, 4, 3, 1'b1);
    new_vec(2, 0, 7, 1'b1, 4);  set_car(2, 4, 19, 7, 1'b1);
    new_vec(3, 19, 7, 1'b1, 1); set_car(3, 1, 0, 7, 1'b1);
    new_vec(4, 0, 7, 1'b0, 0);  set_car(4, 3, 18, 7, 1'b1);
    new_vec(5, 5, 3, 1'b0, 0);  set_car(5, 0, 5, 4, 1'b1); set_car(5, 5, 5, 3, 1'b0);
    new_vec(6, 10, 10, 1'b1, 7); set_car(6, 7, 10, 10, 1'b1);
    new_vec(7, 5, 3, 1'b1, 0);  set_car(7, 0, 5, 3, 1'b1); set_car(7, 1, 6, 3, 1'b1);

    rst       = 1'b1;
    start     = 1'b0;
    frog_x_in = '0;
    frog_y_in = '0;
    clear_cars();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset collided", collided, 0);
    check("reset hit_idx", hit_idx, 0);
    check("reset car_idx", car_idx, 0);

    for (int v = 0; v < NV; v++) begin
      load_vec(v);
      do_scan(vecs[v].fx, vecs[v].fy, lat);
      check($sformatf("vec%0d latency", v), lat, NC + 2);
      check($sformatf("vec%0d collided", v), collided, vecs[v].exp_col);
      check($sformatf("vec%0d hit_idx", v), hit_idx, vecs[v].exp_idx);
    end

    // Start pulses during SCAN and DRAIN are ignored.
    load_vec(1);
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1; frog_x_in = CW'(5); frog_y_in = CW'(3);
    @(negedge clk);                 // t+1
    start = 1'b0;
    check("scan idx0 presented", car_idx, 0);
    check("scan busy", busy, 1);
    repeat (2) @(negedge clk);      // t+3
    start = 1'b1;
    @(negedge clk);                 // t+4
    start = 1'b0;
    repeat (5) @(negedge clk);      // t+9, DRAIN
    start = 1'b1;
    @(negedge clk);                 // t+10
    start = 1'b0;
    check("ignore done at t+10", done, 1);
    check("ignore hit_idx", hit_idx, 2);
    repeat (15) @(negedge clk);
    check("ignore single done", done_cnt - d0, 1);
    check("ignore idle busy", busy, 0);

    // Back-to-back: start in the DONE cycle.
    do_scan(5, 3, lat);
    check("b2b first latency", lat, NC + 2);
    clear_cars();
    mem_x[5] = 0; mem_y[5] = 9; mem_v[5] = 1'b1;
    start = 1'b1; frog_x_in = CW'(19); frog_y_in = CW'(9);
    @(negedge clk);
    start = 1'b0;
    check("b2b busy", busy, 1);
    check("b2b idx0", car_idx, 0);
    check("b2b no done", done, 0);
    check("b2b verdict held", hit_idx, 2);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b second latency", lat, NC + 2);
    check("b2b collided", collided, 1);
    check("b2b hit_idx", hit_idx, 5);

    // Reset mid-scan with a hit already accumulated.
    clear_cars();
    mem_x[1] = 4; mem_y[1] = 3; mem_v[1] = 1'b1;
    @(negedge clk);
    start = 1'b1; frog_x_in = CW'(5); frog_y_in = CW'(3);
    @(negedge clk);                 // t+1
    start = 1'b0;
    repeat (3) @(negedge clk);      // t+4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    check("rst busy", busy, 0);
    check("rst collided", collided, 0);
    check("rst hit_idx", hit_idx, 0);
    check("rst done", done, 0);
    repeat (15) @(negedge clk);
    check("rst no done", done_cnt - d0, 0);
    do_scan(5, 3, lat);
    check("post-rst latency", lat, NC + 2);
    check("post-rst collided", collided, 1);
    check("post-rst hit_idx", hit_idx, 1);

    // Randomized frames against the reference.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NC; k++) begin
        mem_x[k] = $urandom_range(GW - 1, 0);
        mem_y[k] = $urandom_range(2, 0);
        mem_v[k] = ($urandom_range(9, 0) < 7);
      end
      rfx = $urandom_range(GW - 1, 0);
      rfy = $urandom_range(2, 0);
      ref_verdict(rfx, rfy, rcol, ridx);
      do_scan(rfx, rfy, lat);
      check($sformatf("rand%0d latency", it), lat, NC + 2);
      check($sformatf("rand%0d collided", it), collided, rcol);
      check($sformatf("rand%0d hit_idx", it), hit_idx, ridx);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
